pwm_run_ctrl_module: RTL and testbench

Run/stop/fault sequencer for the SVPWM output stage. It turns operator start/stop commands and filtered hardware fault inputs into the enable, emergency-stop and bootstrap-precharge controls of the PWM generator. Enable changes are aligned to PWM carrier period boundaries so that no truncated pulse is emitted. It sits between the system supervisor (commands, faults) and the SVPWM generator (`system_initilization_done_in`, `emergency_stop_in`).

---
 rtl/pwm_run_ctrl_if.sv | 30 +++
 rtl/pwm_run_ctrl_module.sv | 168 ++++++++++++++++
 tb/tb_pwm_run_ctrl_module.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_run_ctrl_if.sv
// Supervisor-side bundle for the PWM run/stop/fault sequencer: commands,
// fault inputs and carrier boundary pulse in; enable, e-stop, precharge,
// fault code and state out.
interface pwm_run_ctrl_if;
  logic       start_cmd_in;
  logic       stop_cmd_in;
  logic       fault_clear_in;
  logic       overcurrent_in;
  logic       gate_fault_in;
  logic       period_start_in;
  logic       pwm_enable_out;
  logic       emergency_stop_out;
  logic       precharge_out;
  logic [1:0] fault_code_out;
  logic [2:0] state_out;

  modport master (
    output start_cmd_in, stop_cmd_in, fault_clear_in,
    output overcurrent_in, gate_fault_in, period_start_in,
    input  pwm_enable_out, emergency_stop_out, precharge_out,
    input  fault_code_out, state_out
  );

  modport slave (
    input  start_cmd_in, stop_cmd_in, fault_clear_in,
    input  overcurrent_in, gate_fault_in, period_start_in,
    output pwm_enable_out, emergency_stop_out, precharge_out,
    output fault_code_out, state_out
  );
endinterface

// File: rtl/pwm_run_ctrl_module.sv
// Run/stop/fault sequencer for the SVPWM output stage.
// Enable transitions are aligned to carrier period boundaries; hardware
// faults are filtered over FAULT_FILTER_CYCLES consecutive cycles.
// Optional feature macro: PWM_PRECHARGE_EN (bootstrap precharge state and
// its down-counter). Without it IDLE goes straight to ALIGN on start and
// precharge_out is tied low; the state encoding does not change.
module pwm_run_ctrl_module #(
  parameter logic [15:0] PRECHARGE_CYCLES    = 16'd10000,
  parameter logic [7:0]  FAULT_FILTER_CYCLES = 8'd4
) (
  input logic           sys_clk,
  input logic           reset_n,
  pwm_run_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRECHARGE = 3'd1;
  localparam logic [2:0] ST_ALIGN     = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_STOPPING  = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [7:0] flt_cnt;
  logic       fault_any;
  logic       fault_hit;
  logic       pre_done;
  logic       pwm_enable_r;
  logic       emergency_stop_r;
  logic       precharge_r;
  logic [1:0] fault_code_r;

  assign fault_any = bus.overcurrent_in | bus.gate_fault_in;
  // Fires exactly once per fault episode: on the edge where the streak
  // reaches FAULT_FILTER_CYCLES; the counter then saturates past the match.
  assign fault_hit = fault_any & (flt_cnt == (FAULT_FILTER_CYCLES - 8'd1));

  // Consecutive-cycle fault filter, saturating at FAULT_FILTER_CYCLES
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt <= 8'd0;
    end else if (!fault_any) begin
      flt_cnt <= 8'd0;
    end else if (flt_cnt != FAULT_FILTER_CYCLES) begin
      flt_cnt <= flt_cnt + 8'd1;
    end
  end

`ifdef PWM_PRECHARGE_EN
  logic [15:0] pre_cnt;

  assign pre_done = (pre_cnt == 16'd0);

  // Precharge down-counter: loaded on start, counts to zero in PRECHARGE
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= 16'd0;
    end else if ((state == ST_IDLE) && (next_state == ST_PRECHARGE)) begin
      pre_cnt <= PRECHARGE_CYCLES - 16'd1;
    end else if ((state == ST_PRECHARGE) && !pre_done) begin
      pre_cnt <= pre_cnt - 16'd1;
    end
  end
`else
  logic unused_precharge_cfg;

  assign pre_done             = 1'b1;
  assign unused_precharge_cfg = ^PRECHARGE_CYCLES;
`endif

  // Next-state decode: fault_hit outranks stop, stop outranks start
  always_comb begin
    next_state = state;
    if ((state != ST_FAULT) && fault_hit) begin
      next_state = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.stop_cmd_in) begin
            next_state = ST_IDLE;
          end else if (bus.start_cmd_in) begin
`ifdef PWM_PRECHARGE_EN
            next_state = ST_PRECHARGE;
`else
            next_state = ST_ALIGN;
`endif
          end
        end
        ST_PRECHARGE: begin
`ifdef PWM_PRECHARGE_EN
          if (bus.stop_cmd_in) begin
            next_state = ST_IDLE;
          end else if (pre_done) begin
            next_state = ST_ALIGN;
          end
`else
          // Unreachable without precharge; fall back to a safe state.
          next_state = ST_IDLE;
`endif
        end
        ST_ALIGN: begin
          if (bus.stop_cmd_in) begin
            next_state = ST_IDLE;
          end else if (bus.period_start_in) begin
            next_state = ST_RUN;
          end
        end
        ST_RUN: begin
          // A boundary pulse coinciding with stop is not consumed here.
          if (bus.stop_cmd_in) begin
            next_state = ST_STOPPING;
          end
        end
        ST_STOPPING: begin
          if (bus.period_start_in) begin
            next_state = ST_IDLE;
          end
        end
        ST_FAULT: begin
          if (bus.fault_clear_in && !fault_any) begin
            next_state = ST_IDLE;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Outputs registered from next_state so they move on the same edge as state
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_enable_r     <= 1'b0;
      emergency_stop_r <= 1'b0;
      precharge_r      <= 1'b0;
      fault_code_r     <= 2'b00;
    end else begin
      pwm_enable_r     <= (next_state == ST_RUN) || (next_state == ST_STOPPING);
      emergency_stop_r <= (next_state == ST_FAULT);
`ifdef PWM_PRECHARGE_EN
      precharge_r      <= (next_state == ST_PRECHARGE);
`else
      precharge_r      <= 1'b0;
`endif
      if ((state != ST_FAULT) && (next_state == ST_FAULT)) begin
        fault_code_r <= {bus.gate_fault_in, bus.overcurrent_in};
      end
    end
  end

  assign bus.pwm_enable_out     = pwm_enable_r;
  assign bus.emergency_stop_out = emergency_stop_r;
  assign bus.precharge_out      = precharge_r;
  assign bus.fault_code_out     = fault_code_r;
  assign bus.state_out          = state;

endmodule

// File: tb/tb_pwm_run_ctrl_module.sv
// Self-checking bench for pwm_run_ctrl_module: directed scenarios followed
// by randomized commands/faults/carrier pulses, all compared cycle by cycle
// against a behavioural reference model.
module tb_pwm_run_ctrl_module;

  localparam logic [15:0] PC  = 16'd8;
  localparam logic [7:0]  FFC = 8'd4;
`ifdef PWM_PRECHARGE_EN
  localparam int PRE_ON = 1;
`else
  localparam int PRE_ON = 0;
`endif

  localparam int M_IDLE = 0, M_PRE = 1, M_ALIGN = 2, M_RUN = 3, M_STOP = 4, M_FAULT = 5;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;

  pwm_run_ctrl_if bus_if ();

  pwm_run_ctrl_module #(
    .PRECHARGE_CYCLES    (PC),
    .FAULT_FILTER_CYCLES (FFC)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_state;
  int m_streak;
  int m_elapsed;
  int m_code;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_state   = M_IDLE;
    m_streak  = 0;
    m_elapsed = 0;
    m_code    = 0;
  endtask

  // One rising edge of the behavioural model
  task automatic model_step(input bit st, input bit sp, input bit cl,
                            input bit oc, input bit gf, input bit ps);
    bit fa;
    bit hit;
    int ns;
    fa  = oc | gf;
    hit = fa && (m_streak + 1 == int'(FFC));
    m_streak = fa ? ((m_streak < 1000) ? m_streak + 1 : m_streak) : 0;
    ns = m_state;
    if (m_state == M_FAULT) begin
      if (cl && !fa) ns = M_IDLE;
    end else if (hit) begin
      ns = M_FAULT;
      m_code = {gf, oc};
    end else begin
      case (m_state)
        M_IDLE: if (!sp && st) begin
          ns = PRE_ON ? M_PRE : M_ALIGN;
          m_elapsed = 0;
        end
        M_PRE: begin
          if (sp) ns = M_IDLE;
          else begin
            m_elapsed++;
            if (m_elapsed == int'(PC)) ns = M_ALIGN;
          end
        end
        M_ALIGN: if (sp) ns = M_IDLE; else if (ps) ns = M_RUN;
        M_RUN:   if (sp) ns = M_STOP;
        M_STOP:  if (ps) ns = M_IDLE;
        default: ns = M_IDLE;
      endcase
    end
    m_state = ns;
  endtask

  task automatic compare_all(input string where);
    chk({where, ".state"}, int'(bus_if.state_out), m_state);
    chk({where, ".en"},    int'(bus_if.pwm_enable_out), (m_state == M_RUN || m_state == M_STOP) ? 1 : 0);
    chk({where, ".estop"}, int'(bus_if.emergency_stop_out), (m_state == M_FAULT) ? 1 : 0);
    chk({where, ".prech"}, int'(bus_if.precharge_out), (m_state == M_PRE) ? 1 : 0);
    chk({where, ".code"},  int'(bus_if.fault_code_out), m_code);
  endtask

  task automatic cyc(input string where, input bit st, input bit sp, input bit cl,
                     input bit oc, input bit gf, input bit ps);
    @(negedge sys_clk);
    bus_if.start_cmd_in    = st;
    bus_if.stop_cmd_in     = sp;
    bus_if.fault_clear_in  = cl;
    bus_if.overcurrent_in  = oc;
    bus_if.gate_fault_in   = gf;
    bus_if.period_start_in = ps;
    @(posedge sys_clk);
    model_step(st, sp, cl, oc, gf, ps);
    #1;
    compare_all(where);
  endtask

  task automatic idle(input string where, input int n);
    for (int i = 0; i < n; i++) cyc(where, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go_run(input string where);
    cyc(where, 1, 0, 0, 0, 0, 0);
    if (PRE_ON != 0) idle(where, int'(PC));
    cyc(where, 0, 0, 0, 0, 0, 1);
    chk({where, ".in_run"}, int'(bus_if.state_out), M_RUN);
  endtask

  initial begin
    int car;
    int car_per;
    int burst;
    int line;
    bit st, sp, cl, oc, gf, ps;

    bus_if.start_cmd_in    = 1'b0;
    bus_if.stop_cmd_in     = 1'b0;
    bus_if.fault_clear_in  = 1'b0;
    bus_if.overcurrent_in  = 1'b0;
    bus_if.gate_fault_in   = 1'b0;
    bus_if.period_start_in = 1'b0;
    model_reset();

    // Reset values
    repeat (2) @(posedge sys_clk);
    #1;
    compare_all("reset");
    @(negedge sys_clk);
    reset_n = 1'b1;

    // Nominal start; a pulse on the ALIGN-entry edge must not be used
    idle("pre_idle", 3);
    if (PRE_ON != 0) begin
      cyc("start", 1, 0, 0, 0, 0, 0);
      chk("prech_first", int'(bus_if.precharge_out), 1);
      idle("precharge", int'(PC) - 1);
      cyc("align_entry", 0, 0, 0, 0, 0, 1);
    end else begin
      cyc("align_entry", 1, 0, 0, 0, 0, 1);
    end
    chk("align_ignores_ps", int'(bus_if.state_out), M_ALIGN);
    idle("align_wait", 2);
    chk("align_no_en", int'(bus_if.pwm_enable_out), 0);
    cyc("first_ps", 0, 0, 0, 0, 0, 1);
    chk("run_en", int'(bus_if.pwm_enable_out), 1);

    // Stop coinciding with a boundary: pulse not consumed
    cyc("stop_ps", 0, 1, 0, 0, 0, 1);
    chk("stopping", int'(bus_if.state_out), M_STOP);
    idle("stopping_wait", 3);
    chk("stopping_en", int'(bus_if.pwm_enable_out), 1);
    cyc("stop_edge", 0, 0, 0, 0, 0, 1);
    chk("stopped_en", int'(bus_if.pwm_enable_out), 0);
    chk("stopped_state", int'(bus_if.state_out), M_IDLE);

    // Fault filter: 3-cycle glitch ignored, 4-cycle fault latches
    go_run("run2");
    for (int i = 0; i < 3; i++) cyc("oc_glitch", 0, 0, 0, 1, 0, 0);
    cyc("oc_gap", 0, 0, 0, 0, 0, 0);
    chk("glitch_no_fault", int'(bus_if.state_out), M_RUN);
    for (int i = 0; i < 4; i++) cyc("oc_fault", 0, 0, 0, 1, 0, 0);
    chk("fault_estop", int'(bus_if.emergency_stop_out), 1);
    chk("fault_en_off", int'(bus_if.pwm_enable_out), 0);
    chk("fault_code", int'(bus_if.fault_code_out), 1);

    // Fault clear only when the fault is gone
    cyc("clr_busy", 0, 0, 1, 0, 1, 0);
    chk("clr_ignored", int'(bus_if.state_out), M_FAULT);
    idle("fault_drop", 2);
    cyc("clr_ok", 0, 0, 1, 0, 0, 0);
    chk("clr_idle", int'(bus_if.state_out), M_IDLE);
    chk("clr_estop", int'(bus_if.emergency_stop_out), 0);
    chk("clr_code_kept", int'(bus_if.fault_code_out), 1);

    // Start and stop together in IDLE
    cyc("start_stop", 1, 1, 0, 0, 0, 0);
    chk("start_stop_idle", int'(bus_if.state_out), M_IDLE);

    // Asynchronous reset between edges mid-RUN
    go_run("run3");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_en", int'(bus_if.pwm_enable_out), 0);
    chk("async_state", int'(bus_if.state_out), M_IDLE);
    chk("async_estop", int'(bus_if.emergency_stop_out), 0);
    model_reset();
    @(negedge sys_clk);
    reset_n = 1'b1;
    go_run("after_reset");

    // Randomized traffic
    car     = 0;
    car_per = 11;
    burst   = 0;
    line    = 1;
    for (int n = 0; n < 3000; n++) begin
      if (burst == 0 && $urandom_range(0, 24) == 0) begin
        burst = int'($urandom_range(1, 7));
        line  = int'($urandom_range(1, 3));
      end
      oc = (burst > 0) && line[0];
      gf = (burst > 0) && line[1];
      if (burst > 0) burst--;
      ps = (car == 0);
      car = (car + 1) % car_per;
      if (ps && $urandom_range(0, 7) == 0) car_per = int'($urandom_range(3, 15));
      st = ($urandom_range(0, 9) == 0);
      sp = ($urandom_range(0, 29) == 0);
      cl = ($urandom_range(0, 5) == 0);
      cyc("rand", st, sp, cl, oc, gf, ps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
